// File: rtl/proc_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: drives PC, latches IR, emits datapath controls.
// Build option: define PROC_SUB_EN to decode opcode 0100 as SUB Rx,Ry (otherwise it is illegal).
module proc_sequencer #(
    parameter int ADDR_W = 5,
    parameter int CODE_W = 23,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CODE_W-1:0] code,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       imm,
    output logic [3:0]        bus_sel,
    output logic [NREG-1:0]   r_in,
    output logic              a_in,
    output logic              g_in,
    output logic              add_sub,
    output logic              done,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_T1, S_T2, S_T3, S_HALT} state_t;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_MOV  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] SEL_IMM  = 4'd8;
    localparam logic [3:0] SEL_G    = 4'd9;
    localparam logic [3:0] SEL_NONE = 4'd15;

`ifdef PROC_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    state_t              state_reg, state_next;
    logic [CODE_W-1:0]   ir_reg;
    logic [ADDR_W-1:0]   pc_reg;
    logic                halted_reg, illegal_reg;

    logic [3:0]          op;
    logic [2:0]          rx, ry;
    logic                is_sub, is_alu, is_halt, op_known;
    logic [NREG-1:0]     rx_onehot;
    logic                r_we;

    assign op = ir_reg[CODE_W-1 -: 4];
    assign rx = ir_reg[CODE_W-5 -: 3];
    assign ry = ir_reg[CODE_W-8 -: 3];

    assign is_sub   = SUB_EN && (op == OP_SUB);
    assign is_alu   = (op == OP_ADD) || is_sub;
    assign is_halt  = (op == OP_HALT);
    assign op_known = is_halt || (op == OP_LOAD) || (op == OP_MOV) || is_alu;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rx_dec
            assign rx_onehot[gi] = (32'(rx) == gi);
        end
    endgenerate

    // State and architectural registers; IR is captured on the edge leaving FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            ir_reg      <= '0;
            pc_reg      <= '0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH)
                ir_reg <= code;
            if (done && !(state_reg == S_T1 && is_halt))
                pc_reg <= pc_reg + ADDR_W'(1);
            if (state_reg == S_T1 && is_halt)
                halted_reg <= 1'b1;
            if (state_reg == S_T1 && !op_known)
                illegal_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = run ? S_FETCH : S_IDLE;
            S_FETCH: state_next = S_T1;
            S_T1: begin
                if (is_halt)
                    state_next = S_HALT;
                else if (is_alu)
                    state_next = S_T2;
                else
                    state_next = run ? S_FETCH : S_IDLE;
            end
            S_T2:    state_next = S_T3;
            S_T3:    state_next = run ? S_FETCH : S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Moore control decode from state and IR only.
    always_comb begin
        bus_sel = SEL_NONE;
        r_we    = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        case (state_reg)
            S_T1: begin
                if (op == OP_LOAD) begin
                    bus_sel = SEL_IMM;
                    r_we    = 1'b1;
                    done    = 1'b1;
                end else if (op == OP_MOV) begin
                    bus_sel = {1'b0, ry};
                    r_we    = 1'b1;
                    done    = 1'b1;
                end else if (is_alu) begin
                    bus_sel = {1'b0, rx};
                    a_in    = 1'b1;
                end else begin
                    done    = 1'b1;
                end
            end
            S_T2: begin
                bus_sel = {1'b0, ry};
                g_in    = 1'b1;
                add_sub = is_sub;
            end
            S_T3: begin
                bus_sel = SEL_G;
                r_we    = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign r_in    = r_we ? rx_onehot : '0;
    assign pc      = pc_reg;
    assign imm     = ir_reg[15:0];
    assign halted  = halted_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: bench ROM plus a small register-file/ALU datapath model.
module tb_proc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [22:0] code;
    logic [4:0]  pc;
    logic [15:0] imm;
    logic [3:0]  bus_sel;
    logic [7:0]  r_in;
    logic        a_in, g_in, add_sub, done, halted, illegal;

    logic [22:0] rom [32];
    logic [15:0] regs [8];
    logic [15:0] a_reg, g_reg, bus;
    logic        model_clr = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    proc_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .code(code), .pc(pc), .imm(imm),
        .bus_sel(bus_sel), .r_in(r_in), .a_in(a_in), .g_in(g_in), .add_sub(add_sub),
        .done(done), .halted(halted), .illegal(illegal)
    );

    assign code = rom[pc];

    always_comb begin
        bus = 16'h0;
        if (bus_sel < 4'd8) bus = regs[bus_sel[2:0]];
        else if (bus_sel == 4'd8) bus = imm;
        else if (bus_sel == 4'd9) bus = g_reg;
    end

    always @(posedge clk) begin
        if (model_clr) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
            a_reg <= 16'h0;
            g_reg <= 16'h0;
        end else begin
            if (a_in) a_reg <= bus;
            if (g_in) g_reg <= add_sub ? a_reg - bus : a_reg + bus;
            for (int i = 0; i < 8; i++) if (r_in[i]) regs[i] <= bus;
        end
    end

    function automatic logic [22:0] enc_imm(input logic [3:0] op, input logic [2:0] rx, input logic [15:0] v);
        return {op, rx, v};
    endfunction
    function automatic logic [22:0] enc_rr(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {op, rx, ry, 13'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and sample on the falling edge; check per-cycle exclusivity rules.
    task automatic tick();
        @(negedge clk);
        chk("r_in_onehot0", 32'($onehot0(r_in)), 32'd1);
        chk("ctrl_exclusive", 32'((int'(a_in) + int'(g_in) + int'(|r_in)) <= 1), 32'd1);
    endtask

    task automatic apply_reset(input logic start_run);
        rst = 1'b1;
        model_clr = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        model_clr = 1'b0;
        run = start_run;
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            tick();
            n++;
        end
        chk(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_a_in(input string name, input int bound);
        int n = 0;
        while (!a_in && n < bound) begin
            tick();
            n++;
        end
        chk(name, 32'(a_in), 32'd1);
    endtask

    typedef struct {
        logic        run;
        logic [4:0]  pc;
        logic [3:0]  bus_sel;
        logic [7:0]  r_in;
        logic        a_in, g_in, add_sub, done;
        logic [15:0] imm;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        int dones;

        vecs[0] = '{1'b1, 5'd0, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 5'd0, 4'd8,  8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 16'd12};
        vecs[2] = '{1'b1, 5'd1, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd12};
        vecs[3] = '{1'b1, 5'd1, 4'd8,  8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 16'd9};
        vecs[4] = '{1'b1, 5'd2, 4'd15, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9};
        vecs[5] = '{1'b1, 5'd2, 4'd8,  8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5};

        // Standard program
        for (int i = 0; i < 32; i++) rom[i] = 23'd0;
        rom[0]  = enc_imm(4'b0001, 3'd0, 16'd12);
        rom[1]  = enc_imm(4'b0001, 3'd1, 16'd9);
        rom[2]  = enc_imm(4'b0001, 3'd2, 16'd5);
        rom[3]  = enc_imm(4'b0001, 3'd3, 16'd20);
        rom[4]  = enc_imm(4'b0001, 3'd4, 16'd13);
        rom[5]  = enc_imm(4'b0001, 3'd5, 16'd7);
        rom[6]  = enc_imm(4'b0001, 3'd6, 16'd2);
        rom[7]  = enc_imm(4'b0001, 3'd7, 16'd30);
        rom[8]  = enc_rr(4'b0010, 3'd0, 3'd4);
        rom[9]  = enc_rr(4'b0010, 3'd5, 3'd7);
        rom[10] = enc_rr(4'b0010, 3'd2, 3'd1);
        rom[11] = enc_rr(4'b0011, 3'd3, 3'd0);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd15);
        chk("rst_ctrl", {imm, r_in, a_in, g_in, add_sub, done, halted, illegal, 2'b00}, 32'd0);

        apply_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
            chk($sformatf("vec%0d_bus_sel", i), 32'(bus_sel), 32'(vecs[i].bus_sel));
            chk($sformatf("vec%0d_r_in", i), 32'(r_in), 32'(vecs[i].r_in));
            chk($sformatf("vec%0d_ctrl", i), {28'd0, a_in, g_in, add_sub, done},
                {28'd0, vecs[i].a_in, vecs[i].g_in, vecs[i].add_sub, vecs[i].done});
            chk($sformatf("vec%0d_imm", i), 32'(imm), 32'(vecs[i].imm));
            run = vecs[i].run;
        end

        n = 0;
        while (!(a_in && pc == 5'd11) && n < 60) begin
            tick();
            n++;
        end
        chk("add_t1_reached", 32'(a_in && pc == 5'd11), 32'd1);
        chk("add_t1_bus_sel", 32'(bus_sel), 32'd3);
        tick();
        chk("add_t2_bus_sel", 32'(bus_sel), 32'd0);
        chk("add_t2_ctrl", {29'd0, g_in, add_sub, a_in}, {29'd0, 1'b1, 1'b0, 1'b0});
        tick();
        chk("add_t3_bus_sel", 32'(bus_sel), 32'd9);
        chk("add_t3_r_in", 32'(r_in), 32'h08);
        chk("add_t3_done", 32'(done), 32'd1);
        tick();
        chk("add_next_pc", 32'(pc), 32'd12);
        chk("add_next_done", 32'(done), 32'd0);
        run_to_halt("std_halt", 10);
        run = 1'b0;
        tick();
        run = 1'b1;
        repeat (3) tick();
        chk("std_pc", 32'(pc), 32'd12);
        chk("std_halt_idle", {24'd0, bus_sel, done, a_in, g_in, |r_in}, {24'd0, 4'd15, 4'd0});
        chk("std_illegal", 32'(illegal), 32'd0);
        chk("std_r0", 32'(regs[0]), 32'd13);
        chk("std_r2", 32'(regs[2]), 32'd9);
        chk("std_r3", 32'(regs[3]), 32'd33);
        chk("std_r5", 32'(regs[5]), 32'd30);
        $display("INFO standard program done: R0=%0d R2=%0d R3=%0d R5=%0d pc=%0d",
                 regs[0], regs[2], regs[3], regs[5], pc);

        // Drop run mid-ADD
        for (int i = 0; i < 32; i++) rom[i] = 23'd0;
        rom[0] = enc_imm(4'b0001, 3'd3, 16'd5);
        rom[1] = enc_rr(4'b0011, 3'd3, 3'd3);
        rom[2] = enc_imm(4'b0001, 3'd1, 16'd7);
        apply_reset(1'b1);
        wait_a_in("stop_find_add", 20);
        tick();
        chk("stop_t2_g_in", 32'(g_in), 32'd1);
        run = 1'b0;
        tick();
        chk("stop_t3_done", {27'd0, done, r_in[3], bus_sel[3:1]}, {27'd0, 1'b1, 1'b1, 3'b100});
        tick();
        chk("stop_idle_pc", 32'(pc), 32'd2);
        repeat (3) tick();
        chk("stop_hold", {26'd0, pc, done}, {26'd0, 5'd2, 1'b0});
        chk("stop_r3_doubled", 32'(regs[3]), 32'd10);
        run = 1'b1;
        tick();
        chk("resume_fetch_pc", 32'(pc), 32'd2);
        tick();
        chk("resume_load", {bus_sel, r_in, imm[7:0], 12'd0}, {4'd8, 8'h02, 8'd7, 12'd0});
        $display("INFO run-drop test done: pc=%0d R3=%0d", pc, regs[3]);

        // Reset during ADD T2
        apply_reset(1'b1);
        wait_a_in("rst_find_add", 20);
        tick();
        chk("rst_t2_g_in", 32'(g_in), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_pc", 32'(pc), 32'd0);
        chk("rstmid_ctrl", {24'd0, bus_sel, r_in[3], g_in, done, a_in}, {24'd0, 4'd15, 4'd0});
        run = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_no_r_in", {19'd0, pc, r_in}, 32'd0);
        end
        chk("rstmid_r3_kept", 32'(regs[3]), 32'd5);
        $display("INFO reset-abort test done: pc=%0d R3=%0d", pc, regs[3]);

        // PC wrap with an all-MOV ROM
        for (int i = 0; i < 32; i++) rom[i] = enc_rr(4'b0010, 3'd1, 3'd2);
        apply_reset(1'b1);
        dones = 0;
        n = 0;
        while (dones < 32 && n < 200) begin
            tick();
            n++;
            if (done) dones++;
        end
        chk("wrap_dones", 32'(dones), 32'd32);
        chk("wrap_last_pc", 32'(pc), 32'd31);
        tick();
        chk("wrap_pc_zero", 32'(pc), 32'd0);
        chk("wrap_illegal", 32'(illegal), 32'd0);
        $display("INFO wrap test done: dones=%0d pc=%0d", dones, pc);

        // Opcode 0100
        for (int i = 0; i < 32; i++) rom[i] = 23'd0;
        rom[0] = enc_imm(4'b0001, 3'd1, 16'd9);
        rom[1] = enc_imm(4'b0001, 3'd2, 16'd3);
        rom[2] = enc_rr(4'b0100, 3'd1, 3'd2);
        apply_reset(1'b1);
        run_to_halt("sub_halt", 40);
        chk("sub_pc", 32'(pc), 32'd3);
`ifdef PROC_SUB_EN
        chk("sub_r1", 32'(regs[1]), 32'd6);
        chk("sub_illegal", 32'(illegal), 32'd0);
`else
        chk("sub_r1", 32'(regs[1]), 32'd9);
        chk("sub_illegal", 32'(illegal), 32'd1);
`endif
        $display("INFO opcode-0100 test done: R1=%0d illegal=%0d", regs[1], illegal);

        // Undefined opcode acts as NOP
        rom[0] = enc_imm(4'b1010, 3'd5, 16'hFFFF);
        rom[1] = 23'd0;
        apply_reset(1'b1);
        run_to_halt("ill_halt", 20);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_pc", 32'(pc), 32'd1);
        chk("ill_r5", 32'(regs[5]), 32'd0);
        $display("INFO illegal-opcode test done: illegal=%0d pc=%0d", illegal, pc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
